// File: rtl/counter_share_sched.sv
// counter_share_sched
// Round-robin scheduler that lends one WIDTH-bit interval counter to NREQ
// requesters, one window at a time, and pulses a per-requester done when
// a window completes.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - asynchronous active-high reset
//   req       - per-requester request level (bit i = requester i)
//   len       - window lengths, len[i*WIDTH +: WIDTH] belongs to requester i
//   grant     - one-hot current owner of the counter, zero when idle
//   count     - shared counter value
//   busy      - high while in COUNT or DONE
//   done      - one-cycle completion pulse to the finishing requester
//   dbg_state - current FSM state (0 IDLE, 1 COUNT, 2 DONE)
//
// Handshake: a requester holds req high until it sees its done pulse.
// Dropping req while owning the counter aborts the window with no done.
// Requests are only arbitrated in IDLE; len is sampled only at grant time.
module counter_share_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   len,
   output logic [NREQ-1:0]         grant,
   output logic [WIDTH-1:0]        count,
   output logic                    busy,
   output logic [NREQ-1:0]         done,
   output logic [1:0]              dbg_state
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [NREQ-1:0]   grant_n, done_n;
   logic [WIDTH-1:0]  count_n;
   logic [WIDTH-1:0]  win_len, win_len_n;
   logic [PW-1:0]     ptr, ptr_n;
   logic [PW-1:0]     owner, owner_n;
   logic              busy_n;

   // Round-robin pick: first set request scanning ptr, ptr+1, ... mod NREQ.
   logic [PW-1:0]     win;
   logic              found;
   logic [PW:0]       idx;

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
         if (!found && req[idx[PW-1:0]]) begin
            found = 1'b1;
            win   = idx[PW-1:0];
         end
      end
   end

   function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
      if (int'(v) == NREQ - 1) return '0;
      else                     return v + 1'b1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] v);
      return NREQ'(1) << v;
   endfunction

   always_comb begin
      state_n   = state;
      grant_n   = grant;
      count_n   = count;
      done_n    = '0;
      ptr_n     = ptr;
      owner_n   = owner;
      win_len_n = win_len;
      case (state)
         IDLE: begin
            grant_n = '0;
            count_n = '0;
            if (found) begin
               owner_n   = win;
               win_len_n = len[win*WIDTH +: WIDTH];
               if (len[win*WIDTH +: WIDTH] == '0) begin
                  // Empty window: skip COUNT, complete immediately.
                  state_n = DONE;
                  done_n  = onehot(win);
                  ptr_n   = inc_wrap(win);
               end else begin
                  state_n = COUNT;
                  grant_n = onehot(win);
               end
            end
         end
         COUNT: begin
            if (!req[owner]) begin
               // Abort wins over completion: no done for a withdrawn request.
               state_n = IDLE;
               grant_n = '0;
               count_n = '0;
               ptr_n   = inc_wrap(owner);
            end else if (count == win_len - 1'b1) begin
               state_n = DONE;
               grant_n = '0;
               count_n = '0;
               done_n  = onehot(owner);
               ptr_n   = inc_wrap(owner);
            end else begin
               count_n = count + 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
            grant_n = '0;
            count_n = '0;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
            count_n = '0;
         end
      endcase
      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= '0;
         count   <= '0;
         busy    <= 1'b0;
         done    <= '0;
         ptr     <= '0;
         owner   <= '0;
         win_len <= '0;
      end else begin
         state   <= state_n;
         grant   <= grant_n;
         count   <= count_n;
         busy    <= busy_n;
         done    <= done_n;
         ptr     <= ptr_n;
         owner   <= owner_n;
         win_len <= win_len_n;
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_counter_share_sched.sv
// Testbench for counter_share_sched (NREQ=4, WIDTH=4).
// Expected per-cycle output vectors {grant, count, busy, done} are queued
// when stimulus is driven and popped one per cycle at the falling edge.
module tb_counter_share_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam int W     = NREQ + WIDTH + 1 + NREQ;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] len;
   logic [NREQ-1:0]       grant;
   logic [WIDTH-1:0]      count;
   logic                  busy;
   logic [NREQ-1:0]       done;
   logic [1:0]            dbg_state;

   logic [W-1:0]          exp_q[$];
   int                    n_cmp;
   int                    n_bad;

   counter_share_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .len       (len),
      .grant     (grant),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: sim time exceeded, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // checking
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // drivers
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [NREQ-1:0] g, input logic [WIDTH-1:0] c,
                       input logic b, input logic [NREQ-1:0] d);
      exp_q.push_back({g, c, b, d});
   endtask

   task automatic drain(input string tag);
      logic [W-1:0] e;
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check_eq(tag, 32'({grant, count, busy, done}), 32'(e));
      end
   endtask

   task automatic set_len(input int i, input logic [WIDTH-1:0] v);
      len[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [NREQ-1:0] oh;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      req   = '0;
      len   = '0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_grant", 32'(grant), 32'd0);
      check_eq("rst_count", 32'(count), 32'd0);
      check_eq("rst_busy",  32'(busy),  32'd0);
      check_eq("rst_done",  32'(done),  32'd0);
      check_eq("rst_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      // single request, len0=3
      req = 4'b0001;
      set_len(0, 4'd3);
      push(4'b0001, 4'd0, 1'b1, 4'b0000);
      push(4'b0001, 4'd1, 1'b1, 4'b0000);
      push(4'b0001, 4'd2, 1'b1, 4'b0000);
      push(4'b0000, 4'd0, 1'b1, 4'b0001);
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      drain("single");
      req = '0;
      tick();

      // round robin from ptr=0, all len=2
      do_reset();
      for (int i = 0; i < NREQ; i++) set_len(i, 4'd2);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << (k % NREQ);
         push(oh,      4'd0, 1'b1, 4'b0000);
         push(oh,      4'd1, 1'b1, 4'b0000);
         push(4'b0000, 4'd0, 1'b1, oh);
         push(4'b0000, 4'd0, 1'b0, 4'b0000);
      end
      drain("rr");
      req = '0;
      tick();

      // zero length on requester 2 (ptr=1, scan reaches 2)
      req = 4'b0100;
      set_len(2, 4'd0);
      push(4'b0000, 4'd0, 1'b1, 4'b0100);
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      drain("zero_len");
      req = '0;
      tick();

      // abort requester 1 at count=2
      req = 4'b0010;
      set_len(1, 4'd5);
      set_len(0, 4'd1);
      push(4'b0010, 4'd0, 1'b1, 4'b0000);
      push(4'b0010, 4'd1, 1'b1, 4'b0000);
      push(4'b0010, 4'd2, 1'b1, 4'b0000);
      drain("abort_run");
      req = 4'b0000;
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      drain("abort_stop");
      // ptr=2: scan 2,3,0 picks requester 0 over 1
      req = 4'b0011;
      push(4'b0001, 4'd0, 1'b1, 4'b0000);
      push(4'b0000, 4'd0, 1'b1, 4'b0001);
      drain("after_abort");
      req = '0;
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      drain("after_abort_idle");

      // len change mid-window has no effect
      req = 4'b0001;
      set_len(0, 4'd4);
      push(4'b0001, 4'd0, 1'b1, 4'b0000);
      push(4'b0001, 4'd1, 1'b1, 4'b0000);
      drain("len_chg_a");
      set_len(0, 4'd1);
      push(4'b0001, 4'd2, 1'b1, 4'b0000);
      push(4'b0001, 4'd3, 1'b1, 4'b0000);
      push(4'b0000, 4'd0, 1'b1, 4'b0001);
      drain("len_chg_b");
      req = '0;
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      drain("len_chg_idle");

      // reset mid-window at count=3 of len=6
      req = 4'b0001;
      set_len(0, 4'd6);
      for (int k = 0; k < 4; k++) push(4'b0001, WIDTH'(k), 1'b1, 4'b0000);
      drain("pre_rst");
      rst = 1'b1;
      #1;
      check_eq("arst_grant", 32'(grant), 32'd0);
      check_eq("arst_count", 32'(count), 32'd0);
      check_eq("arst_busy",  32'(busy),  32'd0);
      check_eq("arst_done",  32'(done),  32'd0);
      check_eq("arst_state", 32'(dbg_state), 32'd0);
      tick();
      check_eq("arst_hold_done", 32'(done), 32'd0);
      rst = 1'b0;
      req = 4'b1000;
      set_len(3, 4'd2);
      push(4'b1000, 4'd0, 1'b1, 4'b0000);
      push(4'b1000, 4'd1, 1'b1, 4'b0000);
      push(4'b0000, 4'd0, 1'b1, 4'b1000);
      drain("post_rst");
      req = '0;
      push(4'b0000, 4'd0, 1'b0, 4'b0000);
      drain("post_rst_idle");

      // after wrap ptr=0: requesters 0 and 3 both ask, 0 wins
      req = 4'b1001;
      set_len(0, 4'd1);
      push(4'b0001, 4'd0, 1'b1, 4'b0000);
      push(4'b0000, 4'd0, 1'b1, 4'b0001);
      drain("ptr_wrap");
      req = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
